// File: rtl/card_shoe.sv
// rtl/card_shoe.sv - 52-card shoe: LFSR-seeded random draw without replacement.
// A draw starts at a pseudo-random index and walks forward to the first undealt card.
module card_shoe (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       shuffle,
  input  logic       deal_req,
  output logic       deal_valid,
  output logic [3:0] card,
  output logic [1:0] suit,
  output logic       busy,
  output logic [5:0] cards_left,
  output logic       empty
);

  typedef enum logic {
    S_IDLE,
    S_SEARCH
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [5:0]  DECK_SIZE = 6'd52;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;
  logic [51:0] r_used;
  logic [51:0] w_used_nxt;
  logic [5:0]  r_idx;
  logic [5:0]  w_idx_nxt;
  logic [5:0]  r_cards_left;
  logic [5:0]  w_cards_left_nxt;
  logic        r_deal_valid;
  logic        w_deal_valid_nxt;
  logic [3:0]  r_card;
  logic [3:0]  w_card_nxt;
  logic [1:0]  r_suit;
  logic [1:0]  w_suit_nxt;

  logic        w_empty;
  logic [5:0]  w_start_idx;
  logic [5:0]  w_idx_inc;
  logic [63:0] w_used_pad;
  logic [63:0] w_idx_onehot;
  logic        w_idx_used;
  logic [5:0]  w_rem;
  logic [1:0]  w_idx_suit;

  // Fibonacci LFSR, taps 16,14,13,11; free-running in every state
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  assign w_empty     = (r_cards_left == 6'd0);
  assign w_start_idx = (r_lfsr[5:0] < DECK_SIZE) ? r_lfsr[5:0] : (r_lfsr[5:0] - DECK_SIZE);
  assign w_idx_inc   = (r_idx == 6'd51) ? 6'd0 : (r_idx + 6'd1);

  // Padded to 64 bits so a 6-bit index can never select past the mask
  assign w_used_pad   = {12'd0, r_used};
  assign w_idx_onehot = 64'd1 << r_idx;
  assign w_idx_used   = w_used_pad[r_idx];

  always_comb begin
    w_rem      = r_idx;
    w_idx_suit = 2'd0;
    if (r_idx >= 6'd39) begin
      w_rem      = r_idx - 6'd39;
      w_idx_suit = 2'd3;
    end else if (r_idx >= 6'd26) begin
      w_rem      = r_idx - 6'd26;
      w_idx_suit = 2'd2;
    end else if (r_idx >= 6'd13) begin
      w_rem      = r_idx - 6'd13;
      w_idx_suit = 2'd1;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_used_nxt       = r_used;
    w_idx_nxt        = r_idx;
    w_cards_left_nxt = r_cards_left;
    w_deal_valid_nxt = 1'b0;
    w_card_nxt       = r_card;
    w_suit_nxt       = r_suit;

    if (shuffle) begin
      w_state_nxt      = S_IDLE;
      w_used_nxt       = 52'd0;
      w_cards_left_nxt = DECK_SIZE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (deal_req && !w_empty) begin
            w_idx_nxt   = w_start_idx;
            w_state_nxt = S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (w_idx_used) begin
            w_idx_nxt = w_idx_inc;
          end else begin
            w_used_nxt       = r_used | w_idx_onehot[51:0];
            w_card_nxt       = w_rem[3:0] + 4'd1;
            w_suit_nxt       = w_idx_suit;
            w_deal_valid_nxt = 1'b1;
            if (r_cards_left != 6'd0) begin
              w_cards_left_nxt = r_cards_left - 6'd1;
            end
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_used       <= 52'd0;
      r_idx        <= 6'd0;
      r_cards_left <= DECK_SIZE;
      r_deal_valid <= 1'b0;
      r_card       <= 4'd0;
      r_suit       <= 2'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_used       <= w_used_nxt;
      r_idx        <= w_idx_nxt;
      r_cards_left <= w_cards_left_nxt;
      r_deal_valid <= w_deal_valid_nxt;
      r_card       <= w_card_nxt;
      r_suit       <= w_suit_nxt;
    end
  end

  assign deal_valid = r_deal_valid;
  assign card       = r_card;
  assign suit       = r_suit;
  assign busy       = (r_state == S_SEARCH);
  assign cards_left = r_cards_left;
  assign empty      = w_empty;

endmodule

// File: tb/tb_card_shoe.sv
// tb/tb_card_shoe.sv - randomized self-checking bench for card_shoe against a deck model.
module tb_card_shoe;

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic       shuffle  = 1'b0;
  logic       deal_req = 1'b0;
  logic       deal_valid;
  logic [3:0] card;
  logic [1:0] suit;
  logic       busy;
  logic [5:0] cards_left;
  logic       empty;

  card_shoe dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .shuffle    (shuffle),
    .deal_req   (deal_req),
    .deal_valid (deal_valid),
    .card       (card),
    .suit       (suit),
    .busy       (busy),
    .cards_left (cards_left),
    .empty      (empty)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: pseudo-random source plus a deck of 52 flags
  int m_lfsr;
  bit m_used[52];
  int m_left;
  int rank_cnt[14];
  bit seen[52];
  int dup_cnt;

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v / 32768) + (v / 8192) + (v / 4096) + (v / 1024)) % 2;
    fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
    return ((v * 2) + fb) % 65536;
  endfunction

  always @(posedge CLOCK_50 or posedge reset) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= lfsr_next(m_lfsr);
  end

  function automatic int model_start();
    int s;
    s = m_lfsr % 64;
    if (s >= 52) s -= 52;
    return s;
  endfunction

  function automatic int model_skip(input int s);
    for (int k = 0; k < 52; k++)
      if (!m_used[(s + k) % 52]) return k;
    return -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 52; i++) m_used[i] = 1'b0;
    m_left = 52;
  endtask

  // Called just after a negedge; returns just after a negedge
  task automatic do_deal(input string tag);
    int s, sk, idx, waited;
    s   = model_start();
    sk  = model_skip(s);
    idx = (s + sk) % 52;
    deal_req = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    deal_req = 1'b0;
    waited = 0;
    while (deal_valid !== 1'b1 && waited < 60) begin
      @(negedge CLOCK_50);
      waited++;
    end
    check({tag, "_latency"}, waited + 1, sk + 2);
    check({tag, "_card"}, card, idx % 13 + 1);
    check({tag, "_suit"}, suit, idx / 13);
    if (card >= 1 && card <= 13) begin
      rank_cnt[card]++;
      if (seen[suit * 13 + card - 1]) dup_cnt++;
      seen[suit * 13 + card - 1] = 1'b1;
    end
    m_used[idx] = 1'b1;
    m_left--;
    check({tag, "_left"}, cards_left, m_left);
    @(negedge CLOCK_50);
    check({tag, "_pulse"}, deal_valid, 0);
  endtask

  task automatic deal_many(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
      do_deal(tag);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sk, tries;
    model_clear();
    for (int i = 0; i < 14; i++) rank_cnt[i] = 0;
    for (int i = 0; i < 52; i++) seen[i] = 1'b0;
    dup_cnt = 0;

    repeat (2) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("rst_left", cards_left, 52);
    check("rst_empty", empty, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", deal_valid, 0);
    check("rst_card", card, 0);
    check("rst_suit", suit, 0);
    reset = 1'b0;

    // First draw on the first edge after release, then the whole deck
    do_deal("first");
    deal_many(51, "deck");
    for (int r = 1; r <= 13; r++) check("rank_count", rank_cnt[r], 4);
    check("duplicates", dup_cnt, 0);
    check("deck_left", cards_left, 0);
    check("deck_empty", empty, 1);

    deal_req = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge CLOCK_50);
      check("empty_hold", {deal_valid, busy, cards_left}, 0);
    end
    deal_req = 1'b0;

    shuffle = 1'b1;
    @(negedge CLOCK_50);
    shuffle = 1'b0;
    model_clear();
    check("shuf_left", cards_left, 52);
    check("shuf_empty", empty, 0);

    deal_many(51, "pre_shuf");
    deal_req = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    deal_req = 1'b0;
    check("search_busy", busy, 1);
    shuffle = 1'b1;
    @(negedge CLOCK_50);
    shuffle = 1'b0;
    model_clear();
    check("ovr_valid", deal_valid, 0);
    check("ovr_busy", busy, 0);
    check("ovr_left", cards_left, 52);
    check("ovr_empty", empty, 0);
    @(negedge CLOCK_50);
    check("ovr_valid_late", deal_valid, 0);

    // Build a long search, then reset three cycles into it
    deal_many(51, "pre_rst");
    tries = 0;
    sk = model_skip(model_start());
    while (sk < 3 && tries < 300) begin
      @(negedge CLOCK_50);
      tries++;
      sk = model_skip(model_start());
    end
    check("long_search_found", sk >= 3, 1);
    deal_req = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    deal_req = 1'b0;
    repeat (3) @(posedge CLOCK_50);
    #2;
    reset = 1'b1;
    #1;
    check("arst_busy", busy, 0);
    check("arst_valid", deal_valid, 0);
    check("arst_left", cards_left, 52);
    check("arst_empty", empty, 0);
    check("arst_card", card, 0);
    check("arst_suit", suit, 0);
    model_clear();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      check("post_rst_quiet", deal_valid, 0);
    end
    deal_many(8, "post_rst");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
